execute_stage: RTL and testbench

//  Execute stage: sits between decode and memory_stage and owns the EX/MEM pipeline register.
//  - Single-cycle ALU ops.
//  - Load/store address generation into dst_reg_data.
//  - Multi-cycle RV32M mul/div through the muldiv_unit sub-module.
//  - Stalls decode while muldiv is busy or memory_stage stalls.

---
 rtl/execute_stage_pkg.sv | 48 ++++
 rtl/execute_stage_if.sv | 25 ++
 rtl/execute_stage_muldiv_unit.sv | 114 +++++++++++
 rtl/execute_stage.sv | 97 +++++++++
 tb/tb_execute_stage.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/execute_stage_pkg.sv
// Shared types for the execute stage: ALU opcodes, muldiv FSM states, decoded instruction payload.
// Pure declarations, no latency or backpressure of its own.
package execute_stage_pkg;

    localparam int ARCH_LEN        = 32;
    localparam int MUL_LATENCY_DEF = 4;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_SLL,
        ALU_SLT,
        ALU_SLTU,
        ALU_XOR,
        ALU_SRL,
        ALU_SRA,
        ALU_OR,
        ALU_AND
    } alu_op_t;

    typedef enum logic [1:0] {
        MD_IDLE,
        MD_BUSY,
        MD_DONE
    } md_state_t;

    // use_imm selects imm instead of src_data_2 as the second ALU operand
    typedef struct packed {
        logic                valid;
        logic                is_l;
        logic                is_s;
        logic                is_m;
        logic                use_imm;
        alu_op_t             alu_op;
        logic [2:0]          func3;
        logic [ARCH_LEN-1:0] imm;
        logic [ARCH_LEN-1:0] src_data_1;
        logic [ARCH_LEN-1:0] src_data_2;
        logic [4:0]          dst_reg;
        logic [ARCH_LEN-1:0] dst_reg_data;
        logic                reg_data_ready;
    } inst_decoded_t;

    function automatic logic [ARCH_LEN-1:0] negate_if(input logic neg, input logic [ARCH_LEN-1:0] v);
        return neg ? ((~v) + ARCH_LEN'(1)) : v;
    endfunction

endpackage

// File: rtl/execute_stage_if.sv
// Decode -> execute -> memory_stage payload and stall wiring.
// master drives instructions and the downstream stall; slave is the execute stage.
interface execute_stage_if;
    import execute_stage_pkg::*;

    inst_decoded_t inst_exe_in;
    inst_decoded_t inst_exe_out;
    logic          stall_exe_in;
    logic          stall_exe_out;

    modport master (
        output inst_exe_in,
        output stall_exe_in,
        input  inst_exe_out,
        input  stall_exe_out
    );

    modport slave (
        input  inst_exe_in,
        input  stall_exe_in,
        output inst_exe_out,
        output stall_exe_out
    );

endinterface

// File: rtl/execute_stage_muldiv_unit.sv
// RV32M unit: MUL* after MUL_LATENCY busy cycles, DIV*/REM* bit-serial restoring in DIV_CYCLES cycles.
// hold parks a finished result in DONE until downstream is free; result is valid while done=1.
module execute_stage_muldiv_unit
    import execute_stage_pkg::*;
#(
    parameter int MUL_LATENCY = MUL_LATENCY_DEF,
    parameter int DIV_CYCLES  = ARCH_LEN
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                hold,
    input  logic [2:0]          func3,
    input  logic [ARCH_LEN-1:0] op_a,
    input  logic [ARCH_LEN-1:0] op_b,
    output logic                busy,
    output logic                done,
    output logic [ARCH_LEN-1:0] result
);

    localparam int CNT_MAX = (MUL_LATENCY > DIV_CYCLES) ? MUL_LATENCY : DIV_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    md_state_t           state_q, state_d;
    logic [CNT_W-1:0]    cnt_q;
    logic [2:0]          f3_q;
    logic [ARCH_LEN-1:0] a_q, b_q;
    logic [ARCH_LEN-1:0] quo_q, rem_q, dvs_q;
    logic                q_neg_q, r_neg_q;

    logic                  cnt_zero;
    logic                  a_neg, b_neg;
    logic [ARCH_LEN:0]     sh, diff;
    logic [ARCH_LEN-1:0]   quo_n, rem_n, q_fin, r_fin, q_res, r_res, mul_res;
    logic signed [ARCH_LEN:0] a_ext, b_ext;
    logic [2*ARCH_LEN-1:0] prod;

    assign cnt_zero = (cnt_q == '0);
    assign a_neg    = ~func3[0] & op_a[ARCH_LEN-1];
    assign b_neg    = ~func3[0] & op_b[ARCH_LEN-1];

    always_comb begin
        state_d = state_q;
        case (state_q)
            MD_IDLE: if (start) state_d = MD_BUSY;
            MD_BUSY: if (cnt_zero) state_d = hold ? MD_DONE : MD_IDLE;
            MD_DONE: if (!hold) state_d = MD_IDLE;
            default: state_d = MD_IDLE;
        endcase
    end

    // One restoring step on magnitudes: shift in next dividend bit, subtract if it fits
    always_comb begin
        sh    = {rem_q, quo_q[ARCH_LEN-1]};
        diff  = sh - {1'b0, dvs_q};
        rem_n = diff[ARCH_LEN] ? sh[ARCH_LEN-1:0] : diff[ARCH_LEN-1:0];
        quo_n = {quo_q[ARCH_LEN-2:0], ~diff[ARCH_LEN]};
    end

    // In the last BUSY cycle the final step is still combinational; DONE reads the registered copy
    always_comb begin
        q_fin = (state_q == MD_BUSY) ? quo_n : quo_q;
        r_fin = (state_q == MD_BUSY) ? rem_n : rem_q;
        q_res = (b_q == '0) ? '1  : negate_if(q_neg_q, q_fin);
        r_res = (b_q == '0) ? a_q : negate_if(r_neg_q, r_fin);
    end

    // The product is taken from latched operands; the counter sets when it is released
    always_comb begin
        a_ext   = {(f3_q[1:0] != 2'b11) & a_q[ARCH_LEN-1], a_q};
        b_ext   = {(f3_q[1:0] == 2'b01) & b_q[ARCH_LEN-1], b_q};
        prod    = (2*ARCH_LEN)'(a_ext * b_ext);
        mul_res = (f3_q[1:0] == 2'b00) ? prod[ARCH_LEN-1:0] : prod[2*ARCH_LEN-1:ARCH_LEN];
        result  = f3_q[2] ? (f3_q[1] ? r_res : q_res) : mul_res;
    end

    assign busy = (state_q != MD_IDLE);
    assign done = ((state_q == MD_BUSY) & cnt_zero) | (state_q == MD_DONE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= MD_IDLE;
            cnt_q   <= '0;
            f3_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dvs_q   <= '0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (start && state_q == MD_IDLE) begin
                cnt_q   <= func3[2] ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MUL_LATENCY - 1);
                f3_q    <= func3;
                a_q     <= op_a;
                b_q     <= op_b;
                quo_q   <= negate_if(a_neg, op_a);
                dvs_q   <= negate_if(b_neg, op_b);
                rem_q   <= '0;
                q_neg_q <= a_neg ^ b_neg;
                r_neg_q <= a_neg;
            end else if (state_q == MD_BUSY) begin
                if (!cnt_zero) cnt_q <= cnt_q - CNT_W'(1);
                if (f3_q[2]) begin
                    quo_q <= quo_n;
                    rem_q <= rem_n;
                end
            end
        end
    end

endmodule

// File: rtl/execute_stage.sv
// Execute stage with EX/MEM register: ALU and address generation in 1 cycle, RV32M via the muldiv unit.
// EX/MEM holds under stall_exe_in; decode is stalled while an M op is in flight or downstream stalls.
module execute_stage
    import execute_stage_pkg::*;
#(
    parameter int MUL_LATENCY = MUL_LATENCY_DEF,
    parameter int DIV_CYCLES  = ARCH_LEN
) (
    input  logic           clk,
    input  logic           rst,
    execute_stage_if.slave bus
);

    inst_decoded_t       in_inst, pay, out_q;
    logic                stall_in, stall_out;
    logic                md_start, md_busy, md_done, md_emit, accept_alu;
    logic [ARCH_LEN-1:0] md_result, alu_b, alu_res;
    logic [4:0]          shamt;

    assign in_inst  = bus.inst_exe_in;
    assign stall_in = bus.stall_exe_in;

    assign md_start   = ~md_busy & in_inst.valid & in_inst.is_m & ~stall_in;
    assign md_emit    = md_done & ~stall_in;
    assign accept_alu = ~md_busy & in_inst.valid & ~in_inst.is_m;

    // Decode advances on the emit cycle (from BUSY or DONE) so the held M op is consumed exactly once
    assign stall_out = stall_in
                     | (md_busy & ~md_emit)
                     | (~md_busy & in_inst.valid & in_inst.is_m);

    execute_stage_muldiv_unit #(
        .MUL_LATENCY (MUL_LATENCY),
        .DIV_CYCLES  (DIV_CYCLES)
    ) u_muldiv (
        .clk    (clk),
        .rst    (rst),
        .start  (md_start),
        .hold   (stall_in),
        .func3  (in_inst.func3),
        .op_a   (in_inst.src_data_1),
        .op_b   (in_inst.src_data_2),
        .busy   (md_busy),
        .done   (md_done),
        .result (md_result)
    );

    always_comb begin
        alu_b = in_inst.use_imm ? in_inst.imm : in_inst.src_data_2;
        shamt = alu_b[4:0];
        case (in_inst.alu_op)
            ALU_ADD:  alu_res = in_inst.src_data_1 + alu_b;
            ALU_SUB:  alu_res = in_inst.src_data_1 - alu_b;
            ALU_SLL:  alu_res = in_inst.src_data_1 << shamt;
            ALU_SLT:  alu_res = {{(ARCH_LEN-1){1'b0}}, $signed(in_inst.src_data_1) < $signed(alu_b)};
            ALU_SLTU: alu_res = {{(ARCH_LEN-1){1'b0}}, in_inst.src_data_1 < alu_b};
            ALU_XOR:  alu_res = in_inst.src_data_1 ^ alu_b;
            ALU_SRL:  alu_res = in_inst.src_data_1 >> shamt;
            ALU_SRA:  alu_res = $signed(in_inst.src_data_1) >>> shamt;
            ALU_OR:   alu_res = in_inst.src_data_1 | alu_b;
            ALU_AND:  alu_res = in_inst.src_data_1 & alu_b;
            default:  alu_res = '0;
        endcase
    end

    // Loads/stores carry the effective address; memory_stage fills in load data later
    always_comb begin
        pay = '0;
        if (md_emit) begin
            pay                = in_inst;
            pay.valid          = 1'b1;
            pay.dst_reg_data   = md_result;
            pay.reg_data_ready = 1'b1;
        end else if (accept_alu) begin
            pay = in_inst;
            if (in_inst.is_l || in_inst.is_s) begin
                pay.dst_reg_data   = in_inst.src_data_1 + in_inst.imm;
                pay.reg_data_ready = 1'b0;
            end else begin
                pay.dst_reg_data   = alu_res;
                pay.reg_data_ready = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_q <= '0;
        end else if (!stall_in) begin
            out_q <= pay;
        end
    end

    assign bus.inst_exe_out  = out_q;
    assign bus.stall_exe_out = stall_out;

endmodule

// File: tb/tb_execute_stage.sv
// Directed plus randomized checks of execute_stage against a behavioural ALU/RV32M reference.
module tb_execute_stage;
    import execute_stage_pkg::*;

    localparam int MUL_LAT = 4;
    localparam int DIV_CYC = 32;

    logic clk;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    execute_stage_if bus ();

    execute_stage #(
        .MUL_LATENCY (MUL_LAT),
        .DIV_CYCLES  (DIV_CYC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic inst_decoded_t mk_alu(input alu_op_t op, input logic ui,
                                             input logic [31:0] a, input logic [31:0] b,
                                             input logic [31:0] imm);
        inst_decoded_t t;
        t = '0;
        t.valid      = 1'b1;
        t.alu_op     = op;
        t.use_imm    = ui;
        t.src_data_1 = a;
        t.src_data_2 = b;
        t.imm        = imm;
        t.dst_reg    = 5'($urandom_range(1, 31));
        return t;
    endfunction

    function automatic inst_decoded_t mk_ls(input logic ld, input logic [31:0] a,
                                            input logic [31:0] b, input logic [31:0] imm);
        inst_decoded_t t;
        t = mk_alu(ALU_ADD, 1'b0, a, b, imm);
        t.is_l = ld;
        t.is_s = ~ld;
        return t;
    endfunction

    function automatic inst_decoded_t mk_m(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        inst_decoded_t t;
        t = mk_alu(ALU_ADD, 1'b0, a, b, 32'h0);
        t.is_m  = 1'b1;
        t.func3 = f3;
        return t;
    endfunction

    function automatic logic [31:0] ref_alu(input alu_op_t op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        case (op)
            ALU_ADD:  r = a + b;
            ALU_SUB:  r = a - b;
            ALU_SLL:  r = a << (b % 32);
            ALU_SLT:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            ALU_SLTU: r = (a < b) ? 32'd1 : 32'd0;
            ALU_XOR:  r = a ^ b;
            ALU_SRL:  r = a >> (b % 32);
            ALU_SRA:  r = $signed(a) >>> (b % 32);
            ALU_OR:   r = a | b;
            default:  r = a & b;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] ref_m(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb, ua, ub, p;
        logic               ovf;
        sa  = {{32{a[31]}}, a};
        sb  = {{32{b[31]}}, b};
        ua  = {32'h0, a};
        ub  = {32'h0, b};
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        p   = 64'h0;
        case (f3)
            3'd0: begin p = sa * sb; return p[31:0];  end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 32'h0) return 32'hFFFF_FFFF;
                if (ovf) return 32'h8000_0000;
                p = sa / sb;
                return p[31:0];
            end
            3'd5: begin
                if (b == 32'h0) return 32'hFFFF_FFFF;
                p = ua / ub;
                return p[31:0];
            end
            3'd6: begin
                if (b == 32'h0) return a;
                if (ovf) return 32'h0;
                p = sa % sb;
                return p[31:0];
            end
            default: begin
                if (b == 32'h0) return a;
                p = ua % ub;
                return p[31:0];
            end
        endcase
    endfunction

    // Decode holds the M op until stall drops; result expected MUL/DIV count + 1 edges after presentation
    task automatic run_m(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input string tag);
        int          n;
        int          lat;
        logic [31:0] exp;
        exp = ref_m(f3, a, b);
        lat = (f3[2] ? DIV_CYC : MUL_LAT) + 1;
        bus.inst_exe_in = mk_m(f3, a, b);
        #1;
        chk({tag, "_stall"}, 32'(bus.stall_exe_out), 32'd1);
        n = 0;
        do begin
            tick();
            n++;
        end while (bus.inst_exe_out.valid !== 1'b1 && n < 100);
        chk({tag, "_lat"}, n, lat);
        chk({tag, "_res"}, bus.inst_exe_out.dst_reg_data, exp);
        chk({tag, "_rdy"}, 32'(bus.inst_exe_out.reg_data_ready), 32'd1);
        bus.inst_exe_in = '0;
    endtask

    initial begin
        inst_decoded_t t;
        logic [31:0]   exp_dst, prev_dst, op2;
        int            cnt;

        // Reset state
        rst              = 1'b0;
        bus.inst_exe_in  = '0;
        bus.stall_exe_in = 1'b0;
        tick();
        tick();
        chk("rst_valid", 32'(bus.inst_exe_out.valid), 32'd0);
        chk("rst_rdy",   32'(bus.inst_exe_out.reg_data_ready), 32'd0);
        chk("rst_dst",   bus.inst_exe_out.dst_reg_data, 32'd0);
        chk("rst_stall", 32'(bus.stall_exe_out), 32'd0);
        rst = 1'b1;
        tick();

        // ADD overflow wraps
        t = mk_alu(ALU_ADD, 1'b0, 32'h7FFF_FFFF, 32'h1, 32'h0);
        bus.inst_exe_in = t;
        tick();
        chk("add_dst",   bus.inst_exe_out.dst_reg_data, 32'h8000_0000);
        chk("add_valid", 32'(bus.inst_exe_out.valid), 32'd1);
        chk("add_rdy",   32'(bus.inst_exe_out.reg_data_ready), 32'd1);
        chk("add_rd",    32'(bus.inst_exe_out.dst_reg), 32'(t.dst_reg));

        // Load / store address generation
        bus.inst_exe_in = mk_ls(1'b1, 32'h1000, 32'h0, 32'hFFFF_FFFC);
        tick();
        chk("lw_addr", bus.inst_exe_out.dst_reg_data, 32'h0000_0FFC);
        chk("lw_rdy",  32'(bus.inst_exe_out.reg_data_ready), 32'd0);
        bus.inst_exe_in = mk_ls(1'b0, 32'hFFFF_FFF0, 32'hDEAD_BEEF, 32'h20);
        tick();
        chk("sw_addr", bus.inst_exe_out.dst_reg_data, 32'h0000_0010);
        chk("sw_data", bus.inst_exe_out.src_data_2, 32'hDEAD_BEEF);
        bus.inst_exe_in = '0;
        tick();
        chk("bubble_valid", 32'(bus.inst_exe_out.valid), 32'd0);

        // Randomized ALU and address traffic
        for (int i = 0; i < 40; i++) begin
            if (i % 5 == 4) begin
                t = mk_ls(1'($urandom_range(0, 1)), $urandom, $urandom, $urandom);
                exp_dst = t.src_data_1 + t.imm;
            end else begin
                t = mk_alu(alu_op_t'($urandom_range(0, 9)), 1'($urandom_range(0, 1)), $urandom, $urandom, $urandom);
                op2 = t.use_imm ? t.imm : t.src_data_2;
                exp_dst = ref_alu(t.alu_op, t.src_data_1, op2);
            end
            bus.inst_exe_in = t;
            tick();
            chk("rnd_dst", bus.inst_exe_out.dst_reg_data, exp_dst);
            chk("rnd_rdy", 32'(bus.inst_exe_out.reg_data_ready), 32'(!(t.is_l || t.is_s)));
        end
        bus.inst_exe_in = '0;
        tick();

        // Directed M cases including corner values
        run_m(3'd0, 32'hFFFF_FFFF, 32'h2, "mul");
        run_m(3'd3, 32'hFFFF_FFFF, 32'h2, "mulhu");
        run_m(3'd4, 32'h7, 32'h0, "div0");
        run_m(3'd6, 32'h7, 32'h0, "rem0");
        run_m(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, "divovf");
        run_m(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, "removf");
        run_m(3'd4, 32'hFFFF_FFF9, 32'h2, "divneg");
        run_m(3'd6, 32'hFFFF_FFF9, 32'h2, "remneg");

        // Randomized M ops
        for (int i = 0; i < 12; i++) begin
            run_m(3'(i % 8), $urandom, (i == 7) ? 32'h0 : $urandom, "rnd_m");
        end
        tick();

        // Downstream stall during an ALU op: EX/MEM must hold
        bus.inst_exe_in = mk_alu(ALU_XOR, 1'b0, 32'hA5A5_0000, 32'h0000_5A5A, 32'h0);
        tick();
        prev_dst = bus.inst_exe_out.dst_reg_data;
        chk("stl_pre", prev_dst, 32'hA5A5_5A5A);
        bus.stall_exe_in = 1'b1;
        bus.inst_exe_in  = mk_alu(ALU_SUB, 1'b0, 32'h10, 32'h20, 32'h0);
        #1;
        chk("stl_out", 32'(bus.stall_exe_out), 32'd1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stl_hold", bus.inst_exe_out.dst_reg_data, prev_dst);
        end
        bus.stall_exe_in = 1'b0;
        tick();
        chk("stl_rel", bus.inst_exe_out.dst_reg_data, 32'hFFFF_FFF0);
        bus.inst_exe_in = '0;
        tick();

        // Downstream stall arriving just before MUL completion parks the result
        bus.inst_exe_in = mk_m(3'd0, 32'd1234, 32'd5678);
        tick();
        tick();
        tick();
        bus.stall_exe_in = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("done_valid", 32'(bus.inst_exe_out.valid), 32'd0);
            chk("done_stall", 32'(bus.stall_exe_out), 32'd1);
        end
        bus.stall_exe_in = 1'b0;
        tick();
        chk("done_res", bus.inst_exe_out.dst_reg_data, 32'd7006652);
        chk("done_vld", 32'(bus.inst_exe_out.valid), 32'd1);
        bus.inst_exe_in = '0;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.inst_exe_out.valid === 1'b1) cnt++;
        end
        chk("done_once", cnt, 0);

        // Reset is asynchronous: output clears between edges
        bus.inst_exe_in = mk_alu(ALU_OR, 1'b1, 32'hF0, 32'h0, 32'h0F);
        tick();
        chk("arst_pre", bus.inst_exe_out.dst_reg_data, 32'hFF);
        bus.inst_exe_in = '0;
        rst = 1'b0;
        #1;
        chk("arst_valid", 32'(bus.inst_exe_out.valid), 32'd0);
        rst = 1'b1;
        tick();

        // Reset in the middle of a DIV discards it
        bus.inst_exe_in = mk_m(3'd5, 32'd1000, 32'd7);
        for (int i = 0; i < 10; i++) tick();
        bus.inst_exe_in = '0;
        rst = 1'b0;
        #1;
        chk("mid_valid", 32'(bus.inst_exe_out.valid), 32'd0);
        chk("mid_stall", 32'(bus.stall_exe_out), 32'd0);
        tick();
        rst = 1'b1;
        bus.inst_exe_in = mk_alu(ALU_ADD, 1'b0, 32'd5, 32'd6, 32'h0);
        #1;
        chk("post_stall", 32'(bus.stall_exe_out), 32'd0);
        tick();
        chk("post_add", bus.inst_exe_out.dst_reg_data, 32'd11);
        chk("post_vld", 32'(bus.inst_exe_out.valid), 32'd1);
        bus.inst_exe_in = '0;
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.inst_exe_out.valid === 1'b1) cnt++;
        end
        chk("post_nodiv", cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
